// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
//   FIFO controller wrapped around a simple dual-port BRAM. Port A is the
//   write port, port B the read port. A small first-word-fall-through output
//   buffer (obuf) hides the BRAM read latency, so the stream side sees
//   one-word-per-cycle throughput once the pipeline has filled.
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   s_data/s_valid/s_ready   write stream (handshake on s_valid & s_ready)
//   m_data/m_valid/m_ready   read stream  (handshake on m_valid & m_ready)
//   bram_ena/wea/addra/dina  BRAM port A (write)
//   bram_enb/web/addrb/doutb BRAM port B (read, web tied low)
//   data_cnt        words held: in BRAM + in flight + in obuf (registered)

module bram_fifo_ctrl #(
    parameter int data_width        = 24,
    parameter int fifo_depth        = 32,
    parameter int bram_read_latency = 2,
    parameter int simulation_delay  = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [data_width-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [data_width-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          bram_ena,
    output logic                          bram_wea,
    output logic [$clog2(fifo_depth)-1:0] bram_addra,
    output logic [data_width-1:0]         bram_dina,
    output logic                          bram_enb,
    output logic                          bram_web,
    output logic [$clog2(fifo_depth)-1:0] bram_addrb,
    input  logic [data_width-1:0]         bram_doutb,
    output logic [$clog2(fifo_depth)+1:0] data_cnt
);

    localparam int aw       = $clog2(fifo_depth);
    localparam int pw       = aw + 1;                     // pointer width, MSB separates full/empty
    localparam int cntw     = aw + 2;
    localparam int ob_depth = bram_read_latency + 1;
    localparam int cw       = $clog2(ob_depth + 1);       // obuf count width
    localparam int ow       = cw + 2;                     // inflight + obuf occupancy width

    // The RTL itself carries no delays; simulation_delay only exists so the
    // parameter list stays compatible with older wrappers that pass it.
    generate
        if (bram_read_latency < 1 || bram_read_latency > 2 || fifo_depth < 4 ||
            (fifo_depth & (fifo_depth - 1)) != 0 || simulation_delay < 0) begin : g_bad_params
            $error("bram_fifo_ctrl: illegal parameter combination");
        end
    endgenerate

    logic [pw-1:0]                wr_ptr;
    logic [pw-1:0]                rd_ptr;
    logic [pw-1:0]                bram_cnt;
    logic                         wr_hs;
    logic                         pop;
    logic                         issue;
    logic                         arrive;
    logic [bram_read_latency-1:0] rd_vld;
    logic [ow-1:0]                inflight;
    logic [ow-1:0]                occupancy;
    logic [cw-1:0]                obuf_cnt;
    logic [data_width-1:0]        obuf [ob_depth];

    assign bram_cnt = wr_ptr - rd_ptr;
    assign s_ready  = !rst && (bram_cnt != pw'(fifo_depth));
    assign wr_hs    = s_valid && s_ready;

    assign bram_ena   = wr_hs;
    assign bram_wea   = wr_hs;
    assign bram_addra = wr_ptr[aw-1:0];
    assign bram_dina  = s_data;

    assign m_valid = (obuf_cnt != '0);
    assign m_data  = obuf[0];
    assign pop     = m_valid && m_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < bram_read_latency; i++) begin
            inflight = inflight + ow'(rd_vld[i]);
        end
    end

    // Only issue a read if the word is guaranteed a slot in obuf when it
    // lands; counting this cycle's pop keeps streaming at full rate.
    assign occupancy = inflight + ow'(obuf_cnt) - ow'(pop);
    assign issue     = !rst && (bram_cnt != '0) && (occupancy < ow'(ob_depth));
    assign arrive    = rd_vld[bram_read_latency-1];

    assign bram_enb   = issue;
    assign bram_web   = 1'b0;
    assign bram_addrb = rd_ptr[aw-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_cnt <= '0;
        end else begin
            if (wr_hs) wr_ptr <= wr_ptr + pw'(1);
            if (issue) rd_ptr <= rd_ptr + pw'(1);
            // Issue and arrival only move words internally; the total
            // changes on the two handshakes alone.
            data_cnt <= data_cnt + cntw'(wr_hs) - cntw'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld <= '0;
        end else begin
            for (int i = bram_read_latency - 1; i > 0; i--) begin
                rd_vld[i] <= rd_vld[i-1];
            end
            rd_vld[0] <= issue;
        end
    end

    // obuf is a shifting FWFT buffer: head always at entry 0. An arriving
    // word lands at the first free slot after this cycle's pop shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obuf_cnt <= '0;
            for (int i = 0; i < ob_depth; i++) begin
                obuf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ob_depth; i++) begin
                if (arrive && (int'(obuf_cnt) - int'(pop)) == i) begin
                    obuf[i] <= bram_doutb;
                end else if (pop && i < ob_depth - 1) begin
                    obuf[i] <= obuf[(i < ob_depth - 1) ? i + 1 : i];
                end
            end
            obuf_cnt <= obuf_cnt + cw'(arrive) - cw'(pop);
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: two instances (read latency 1 and 2) share the
// same stimulus; each has its own BRAM model and a count-based reference
// model that predicts every output on every cycle.

module tb_bram_fifo_ctrl;

    localparam int depth = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b0;

    logic        s_ready1, m_valid1, ena1, wea1, enb1, web1;
    logic [23:0] m_data1, dina1, doutb1;
    logic [4:0]  addra1, addrb1;
    logic [6:0]  dcnt1;

    logic        s_ready2, m_valid2, ena2, wea2, enb2, web2;
    logic [23:0] m_data2, dina2, doutb2;
    logic [4:0]  addra2, addrb2;
    logic [6:0]  dcnt2;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.data_width(24), .fifo_depth(depth), .bram_read_latency(1), .simulation_delay(10)) dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
        .bram_ena(ena1), .bram_wea(wea1), .bram_addra(addra1), .bram_dina(dina1),
        .bram_enb(enb1), .bram_web(web1), .bram_addrb(addrb1), .bram_doutb(doutb1),
        .data_cnt(dcnt1));

    bram_fifo_ctrl #(.data_width(24), .fifo_depth(depth), .bram_read_latency(2), .simulation_delay(10)) dut2 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
        .bram_ena(ena2), .bram_wea(wea2), .bram_addra(addra2), .bram_dina(dina2),
        .bram_enb(enb2), .bram_web(web2), .bram_addrb(addrb2), .bram_doutb(doutb2),
        .data_cnt(dcnt2));

    // BRAM models: latency 1 (no output register) and latency 2 (output register)
    logic [23:0] mem1 [depth];
    logic [23:0] mem2 [depth];
    logic [23:0] q1a = '0, q2a = '0, q2b = '0;

    always @(posedge clk) begin
        if (ena1 && wea1) mem1[addra1] <= dina1;
        if (enb1) q1a <= mem1[addrb1];
        if (ena2 && wea2) mem2[addra2] <= dina2;
        if (enb2) q2a <= mem2[addrb2];
        q2b <= q2a;
    end
    assign doutb1 = q1a;
    assign doutb2 = q2b;

    int nchecks = 0;
    int nerrors = 0;

    task automatic chk(input string name, input int k, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s (latency %0d): got 0x%0h, expected 0x%0h at %0t", name, k + 1, act, exp, $time);
        end
    endtask

    // Reference model: words are numbered in write order; the FIFO is just
    // four running counts (written, issued, arrived, popped) plus the issue
    // time of each word, so a word lands in obuf latency edges after issue.
    int          wcnt [2] = '{0, 0};
    int          icnt [2] = '{0, 0};
    int          acnt [2] = '{0, 0};
    int          pcnt [2] = '{0, 0};
    int          cyc = 0;
    logic [23:0] wdata [2][64];
    int          itime [2][64];
    logic        dwr [2], dpop [2], diss [2];
    logic [23:0] ds [2];
    logic        prev_mv [2] = '{1'b0, 1'b0};
    logic [23:0] prev_md [2];
    logic        prev_mr = 1'b0;

    task automatic model_check(input int k, input logic sr, input logic mv, input logic [23:0] md,
                               input logic ena, input logic wea, input logic [4:0] adda,
                               input logic [23:0] dina, input logic enb, input logic web,
                               input logic [4:0] addb, input logic [6:0] dc);
        int   lat, nb, ni, no;
        logic e_sr, e_mv, e_pop, e_iss;
        lat = k + 1;
        chk("bram_web", k, int'(web), 0);
        if (rst) begin
            wcnt[k] = 0; icnt[k] = 0; acnt[k] = 0; pcnt[k] = 0;
            chk("rst_s_ready", k, int'(sr), 0);
            chk("rst_m_valid", k, int'(mv), 0);
            chk("rst_m_data", k, int'(md), 0);
            chk("rst_bram_ena", k, int'(ena), 0);
            chk("rst_bram_enb", k, int'(enb), 0);
            chk("rst_data_cnt", k, int'(dc), 0);
            dwr[k] = 1'b0; dpop[k] = 1'b0; diss[k] = 1'b0; prev_mv[k] = 1'b0;
            return;
        end
        nb = wcnt[k] - icnt[k];
        ni = icnt[k] - acnt[k];
        no = acnt[k] - pcnt[k];
        e_sr  = (nb != depth);
        e_mv  = (no != 0);
        e_pop = e_mv && m_ready;
        e_iss = (nb != 0) && ((ni + no - int'(e_pop)) < lat + 1);
        chk("s_ready", k, int'(sr), int'(e_sr));
        chk("m_valid", k, int'(mv), int'(e_mv));
        if (e_mv) chk("m_data", k, int'(md), int'(wdata[k][pcnt[k] % 64]));
        if (prev_mv[k] && !prev_mr && mv) chk("m_data_stall", k, int'(md), int'(prev_md[k]));
        chk("bram_ena", k, int'(ena), int'(s_valid && e_sr));
        chk("bram_wea", k, int'(wea), int'(s_valid && e_sr));
        if (s_valid && e_sr) begin
            chk("bram_addra", k, int'(adda), wcnt[k] % depth);
            chk("bram_dina", k, int'(dina), int'(s_data));
        end
        chk("bram_enb", k, int'(enb), int'(e_iss));
        if (e_iss) chk("bram_addrb", k, int'(addb), icnt[k] % depth);
        chk("data_cnt", k, int'(dc), wcnt[k] - pcnt[k]);
        dwr[k] = s_valid && e_sr; dpop[k] = e_pop; diss[k] = e_iss; ds[k] = s_data;
        prev_mv[k] = mv; prev_md[k] = md;
    endtask

    task automatic model_apply(input int k);
        int lat;
        lat = k + 1;
        if (dwr[k]) begin
            wdata[k][wcnt[k] % 64] = ds[k];
            wcnt[k]++;
        end
        if (acnt[k] < icnt[k] && itime[k][acnt[k] % 64] + lat == cyc) acnt[k]++;
        if (diss[k]) begin
            itime[k][icnt[k] % 64] = cyc;
            icnt[k]++;
        end
        if (dpop[k]) pcnt[k]++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_check(0, s_ready1, m_valid1, m_data1, ena1, wea1, addra1, dina1, enb1, web1, addrb1, dcnt1);
            model_check(1, s_ready2, m_valid2, m_data2, ena2, wea2, addra2, dina2, enb2, web2, addrb2, dcnt2);
            prev_mr = m_ready;
            @(posedge clk);
            cyc++;
            if (!rst) begin
                model_apply(0);
                model_apply(1);
            end
        end
    end

    // Event monitor for the directed phases
    int          pops1 = 0, pops2 = 0, wrapa1 = 0, wrapb1 = 0, maxdc2 = 0;
    logic [23:0] last1 = '0, last2 = '0;
    logic [4:0]  lasta1 = '0, lastb1 = '0;

    always @(negedge clk) begin
        if (m_valid1 && m_ready) begin pops1 <= pops1 + 1; last1 <= m_data1; end
        if (m_valid2 && m_ready) begin pops2 <= pops2 + 1; last2 <= m_data2; end
        if (ena1) begin
            if (addra1 == 5'd0 && lasta1 == 5'd31) wrapa1 <= wrapa1 + 1;
            lasta1 <= addra1;
        end
        if (enb1) begin
            if (addrb1 == 5'd0 && lastb1 == 5'd31) wrapb1 <= wrapb1 + 1;
            lastb1 <= addrb1;
        end
        if (int'(dcnt2) > maxdc2) maxdc2 <= int'(dcnt2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base1, base2, gaps1, gaps2, sr_low, wa, wb;

        step(); step();
        chk("reset_s_ready", 1, int'(s_ready2), 0);
        chk("reset_m_valid", 1, int'(m_valid2), 0);
        chk("reset_data_cnt", 1, int'(dcnt2), 0);
        rst = 1'b0;
        step();
        chk("s_ready_after_rst", 1, int'(s_ready2), 1);
        chk("s_ready_after_rst", 0, int'(s_ready1), 1);

        // single word
        s_data = 24'hABCDEF; s_valid = 1'b1; m_ready = 1'b1;
        step();                                   // E0
        s_valid = 1'b0; s_data = '0;
        chk("single_enb", 1, int'(enb2), 1);
        chk("single_addrb", 1, int'(addrb2), 0);
        chk("single_dcnt", 1, int'(dcnt2), 1);
        step();                                   // E1
        chk("single_mvalid_e1", 1, int'(m_valid2), 0);
        chk("single_mvalid_e1", 0, int'(m_valid1), 0);
        step();                                   // E2
        chk("single_mvalid_e2", 1, int'(m_valid2), 0);
        chk("single_mvalid_e2", 0, int'(m_valid1), 1);
        chk("single_mdata_e2", 0, int'(m_data1), 24'hABCDEF);
        step();                                   // E3
        chk("single_mvalid_e3", 1, int'(m_valid2), 1);
        chk("single_mdata_e3", 1, int'(m_data2), 24'hABCDEF);
        step();                                   // E4
        chk("single_mvalid_e4", 1, int'(m_valid2), 0);
        chk("single_dcnt_e4", 1, int'(dcnt2), 0);

        // streaming
        gaps1 = 0; gaps2 = 0; sr_low = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_data = 24'h100000 + 24'(i);
            if (!s_ready2 || !s_ready1) sr_low++;
            step();
            if (i >= 3 && !m_valid2) gaps2++;
            if (i >= 2 && !m_valid1) gaps1++;
        end
        s_valid = 1'b0;
        chk("stream_gaps", 1, gaps2, 0);
        chk("stream_gaps", 0, gaps1, 0);
        chk("stream_s_ready_low", 1, sr_low, 0);
        for (int i = 0; i < 10; i++) step();
        chk("stream_drained", 1, int'(dcnt2), 0);

        // fill with m_ready low, then drain
        m_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1; s_data = 24'(i);
            step();
        end
        s_valid = 1'b0;
        step(); step();
        chk("fill_data_cnt", 1, int'(dcnt2), 35);
        chk("fill_s_ready", 1, int'(s_ready2), 0);
        chk("fill_data_cnt", 0, int'(dcnt1), 34);
        base1 = pops1; base2 = pops2;
        m_ready = 1'b1;
        for (int i = 0; i < 45; i++) step();
        chk("drain_count", 1, pops2 - base2, 35);
        chk("drain_last", 1, int'(last2), 34);
        chk("drain_count", 0, pops1 - base1, 34);
        chk("drain_last", 0, int'(last1), 33);

        // wrap through a half-full FIFO
        wa = wrapa1; wb = wrapb1;
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_data = 24'h200000 + 24'(i);
            step();
        end
        chk("half_full", 0, int'(dcnt1), 16);
        m_ready = 1'b1;
        for (int i = 0; i < 3 * depth; i++) begin
            s_valid = 1'b1; s_data = 24'h300000 + 24'(i);
            step();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 40; i++) step();
        chk("wrap_addra", 0, int'(wrapa1 > wa), 1);
        chk("wrap_addrb", 0, int'(wrapb1 > wb), 1);
        chk("wrap_drained", 0, int'(dcnt1), 0);

        // random backpressure
        for (int i = 0; i < 2000; i++) begin
            s_valid = ($urandom_range(0, 99) < 70);
            s_data  = 24'($urandom);
            m_ready = ($urandom_range(0, 99) < 30);
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 50; i++) step();
        chk("random_max_data_cnt", 1, int'(maxdc2 <= 35), 1);
        chk("random_drained", 1, int'(dcnt2), 0);

        // reset during traffic
        m_ready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            s_valid = 1'b1; s_data = 24'h400000 + 24'(i);
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        step(); step();
        chk("pre_rst_data_cnt", 1, int'(dcnt2), 20);
        rst = 1'b1; m_ready = 1'b0;
        #1;
        chk("mid_rst_m_valid", 1, int'(m_valid2), 0);
        chk("mid_rst_data_cnt", 1, int'(dcnt2), 0);
        chk("mid_rst_m_valid", 0, int'(m_valid1), 0);
        chk("mid_rst_data_cnt", 0, int'(dcnt1), 0);
        step();
        rst = 1'b0;
        step();
        base1 = pops1; base2 = pops2;
        s_valid = 1'b1; s_data = 24'h000123; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("post_rst_count", 1, pops2 - base2, 1);
        chk("post_rst_word", 1, int'(last2), 24'h000123);
        chk("post_rst_count", 0, pops1 - base1, 1);
        chk("post_rst_word", 0, int'(last1), 24'h000123);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
